alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles the ALU operands are held before result sampling (legal 1..15).
REQ-002 SHALL have port Clk input 1: single clock, all state on its rising edge.
REQ-003 SHALL have port Reset input 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid input 1: request present.
REQ-005 SHALL have port req_ready output 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_opcode input 6: MIPS opcode field.
REQ-007 SHALL have port req_funct input 6: MIPS funct field (R-type only).
REQ-008 SHALL have port req_rs_data input 32: rs operand.
REQ-009 SHALL have port req_rt_data input 32: rt operand.
REQ-010 SHALL have port req_imm input 16: immediate field.
REQ-011 SHALL have port alu_src1 output 32: ALU operand 1.
REQ-012 SHALL have port alu_src2 output 32: ALU operand 2.
REQ-013 SHALL have port alu_ctr output 3: ALU operation select.
REQ-014 SHALL have port alu_result input 32: ALU result.
REQ-015 SHALL have port zero_bit input 1: ALU result-is-zero flag.
REQ-016 SHALL have port rsp_valid output 1: response present.
REQ-017 SHALL have port rsp_ready input 1: consumer accepts response.
REQ-018 SHALL have port rsp_result output 32: captured ALU result.
REQ-019 SHALL have port rsp_zero output 1: captured zero_bit.
REQ-020 SHALL have port rsp_branch_taken output 1: beq and zero.
REQ-021 SHALL have port rsp_illegal output 1: unsupported instruction.

Function
REQ-022 SHALL implement FSM states IDLE, EXEC, RESP; req_ready=1 only in IDLE.
REQ-023 SHALL accept a request on a rising edge with req_valid&&req_ready, registering decode results and moving IDLE->EXEC (legal) or IDLE->RESP (illegal).
REQ-024 SHALL decode alu_ctr: opcode 0x00 with funct 0x20->010 (add), 0x22->110 (sub), 0x24->000 (and), 0x25->001 (or), 0x2A->111 (slt); opcode 0x08->010, 0x0A->111, 0x0C->000, 0x0D->001, 0x04 (beq)->110; everything else illegal.
REQ-025 SHALL drive alu_src1=rs; alu_src2=rt for R-type and beq, sign-extended imm for 0x08/0x0A, zero-extended imm for 0x0C/0x0D.
REQ-026 SHALL hold alu_src1, alu_src2, alu_ctr stable from the cycle after accept until the next accept.
REQ-027 SHALL remain in EXEC exactly ALU_LAT cycles via a down-counter, sampling alu_result and zero_bit at the final EXEC edge and moving to RESP.
REQ-028 SHALL assert rsp_valid in RESP, keep rsp_* stable while rsp_valid&&!rsp_ready, and return to IDLE on the edge where rsp_ready=1.
REQ-029 SHALL set rsp_branch_taken=1 only for opcode 0x04 with sampled zero_bit=1.
REQ-030 SHALL for illegal requests give rsp_illegal=1, rsp_result=0, rsp_zero=0, rsp_branch_taken=0, leave ALU outputs unchanged, rsp_valid in the cycle after accept.
REQ-031 SHALL give legal-request latency: accept at edge 0, rsp_valid high from cycle ALU_LAT+1.
REQ-032 SHALL ignore req_valid and all req_* inputs outside IDLE; back-to-back throughput is one request per ALU_LAT+2 cycles minimum.

Reset
REQ-033 SHALL on Reset=0 immediately force state IDLE, counter 0, alu_src1=0, alu_src2=0, alu_ctr=000, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_branch_taken=0, rsp_illegal=0.
REQ-034 SHALL abandon any in-flight request when Reset asserts mid-EXEC or mid-RESP, producing no response for it.

Verification
REQ-035 SHALL pass: add opcode 0, funct 0x20, rs=5, rt=7, ALU_LAT=1 -> alu_ctr=010, rsp_valid in cycle 2, rsp_result=12, rsp_zero=0.
REQ-036 SHALL pass: addi 0x08, rs=1, imm=0xFFFF -> alu_src2=0xFFFFFFFF, rsp_result=0, rsp_zero=1; ori 0x0D, imm=0xFFFF -> alu_src2=0x0000FFFF.
REQ-037 SHALL pass: beq 0x04, rs=rt=0x1234 -> alu_ctr=110, rsp_branch_taken=1; rs=1, rt=2 -> rsp_branch_taken=0.
REQ-038 SHALL pass: opcode 0x3F -> rsp_illegal=1, rsp_result=0, rsp_valid in cycle 1, alu_* unchanged.
REQ-039 SHALL pass: rsp_ready held 0 for 5 cycles with ALU_LAT=3 -> rsp_* stable, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-040 SHALL pass: Reset pulsed low during EXEC -> all outputs at reset values asynchronously, no rsp_valid afterwards until a new accept.

Source files
------------

// File: rtl/alu_issue.sv
// Single-issue MIPS ALU front end: decodes one request, drives the external ALU
// for ALU_LAT cycles, then holds the captured result until the consumer takes it.
module alu_issue #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_rs_data,
  input  logic [31:0] req_rt_data,
  input  logic [15:0] req_imm,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        zero_bit,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_branch_taken,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [2:0] CTR_AND = 3'b000;
  localparam logic [2:0] CTR_OR  = 3'b001;
  localparam logic [2:0] CTR_ADD = 3'b010;
  localparam logic [2:0] CTR_SUB = 3'b110;
  localparam logic [2:0] CTR_SLT = 3'b111;
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        beq_q;
  logic [31:0] alu_src1_q, alu_src2_q;
  logic [2:0]  alu_ctr_q;
  logic        rsp_valid_q, rsp_zero_q, rsp_bt_q, rsp_illegal_q;
  logic [31:0] rsp_result_q;

  logic        dec_legal, dec_beq;
  logic [2:0]  dec_ctr;
  logic [31:0] dec_src2;
  logic [31:0] imm_sext, imm_zext;

  assign imm_sext = {{16{req_imm[15]}}, req_imm};
  assign imm_zext = {16'h0000, req_imm};

  always_comb begin
    dec_legal = 1'b1;
    dec_beq   = 1'b0;
    dec_ctr   = CTR_AND;
    dec_src2  = req_rt_data;
    case (req_opcode)
      6'h00: begin
        case (req_funct)
          6'h20:   dec_ctr = CTR_ADD;
          6'h22:   dec_ctr = CTR_SUB;
          6'h24:   dec_ctr = CTR_AND;
          6'h25:   dec_ctr = CTR_OR;
          6'h2A:   dec_ctr = CTR_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08:   begin dec_ctr = CTR_ADD; dec_src2 = imm_sext; end
      6'h0A:   begin dec_ctr = CTR_SLT; dec_src2 = imm_sext; end
      6'h0C:   begin dec_ctr = CTR_AND; dec_src2 = imm_zext; end
      6'h0D:   begin dec_ctr = CTR_OR;  dec_src2 = imm_zext; end
      6'h04:   begin dec_ctr = CTR_SUB; dec_beq  = 1'b1;     end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      req_ready_q   <= 1'b1;
      beq_q         <= 1'b0;
      alu_src1_q    <= 32'd0;
      alu_src2_q    <= 32'd0;
      alu_ctr_q     <= 3'b000;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_bt_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (dec_legal) begin
              alu_src1_q <= req_rs_data;
              alu_src2_q <= dec_src2;
              alu_ctr_q  <= dec_ctr;
              beq_q      <= dec_beq;
              cnt_q      <= CNT_INIT;
              state_q    <= EXEC;
            end else begin
              // Illegal requests skip the ALU entirely; its operands stay as they were.
              rsp_valid_q   <= 1'b1;
              rsp_result_q  <= 32'd0;
              rsp_zero_q    <= 1'b0;
              rsp_bt_q      <= 1'b0;
              rsp_illegal_q <= 1'b1;
              state_q       <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= alu_result;
            rsp_zero_q    <= zero_bit;
            rsp_bt_q      <= beq_q & zero_bit;
            rsp_illegal_q <= 1'b0;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign alu_src1         = alu_src1_q;
  assign alu_src2         = alu_src2_q;
  assign alu_ctr          = alu_ctr_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_result       = rsp_result_q;
  assign rsp_zero         = rsp_zero_q;
  assign rsp_branch_taken = rsp_bt_q;
  assign rsp_illegal      = rsp_illegal_q;

endmodule
